// File: rtl/i2c_target_if.sv
// Bus and user-side signals of the I2C target, grouped for port connection.
// The slave modport is the target's view; the master modport is its environment.
interface i2c_target_if;
  logic       scl_i;
  logic       sda_i;
  logic       sda_o;
  logic       sda_oen_o;
  logic [7:0] rx_data_o;
  logic       rx_valid_o;
  logic       rx_ready_i;
  logic [7:0] tx_data_i;
  logic       tx_req_o;
  logic       start_o;
  logic       rw_o;
  logic       stop_o;
  logic       busy_o;

  modport slave (
    input  scl_i, sda_i, rx_ready_i, tx_data_i,
    output sda_o, sda_oen_o, rx_data_o, rx_valid_o, tx_req_o,
           start_o, rw_o, stop_o, busy_o
  );

  modport master (
    output scl_i, sda_i, rx_ready_i, tx_data_i,
    input  sda_o, sda_oen_o, rx_data_o, rx_valid_o, tx_req_o,
           start_o, rw_o, stop_o, busy_o
  );
endinterface

// File: rtl/i2c_target.sv
// I2C target (slave) with a 7-bit address, oversampled from clk_i.
// SCL/SDA are synchronized, edges found against a delayed copy, and a small
// FSM walks address / write-data / read-data bytes with their ACK slots.
// The target never stretches SCL and only ever pulls SDA low (open drain).
module i2c_target #(
  parameter logic [6:0] ADDR = 7'h50
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  i2c_target_if.slave  bus
);

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_ADDR     = 3'd1;
  localparam logic [2:0] ST_ADDR_ACK = 3'd2;
  localparam logic [2:0] ST_RX_DATA  = 3'd3;
  localparam logic [2:0] ST_RX_ACK   = 3'd4;
  localparam logic [2:0] ST_TX_DATA  = 3'd5;
  localparam logic [2:0] ST_TX_ACK   = 3'd6;

  // Synchronizer chains plus the previous synchronized value for edge detection
  logic scl_meta_q, scl_sync_q, scl_prev_q;
  logic sda_meta_q, sda_sync_q, sda_prev_q;

  logic [2:0] state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] shift_q, shift_d;
  logic       phase_q, phase_d;       // 1 once the 9th-bit slot has begun
  logic       ack_q, ack_d;           // whether the current RX byte is ACKed
  logic       addressed_q, addressed_d;
  logic       oen_q, oen_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic       tx_req_q, tx_req_d;
  logic       start_q, start_d;
  logic       rw_q, rw_d;
  logic       stop_q, stop_d;
  logic       busy_q, busy_d;

  logic scl_rise_s, scl_fall_s, start_det_s, stop_det_s;

  // Two-flop synchronizers (preset high = idle bus) and edge-history flops
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      scl_meta_q <= 1'b1;
      scl_sync_q <= 1'b1;
      scl_prev_q <= 1'b1;
      sda_meta_q <= 1'b1;
      sda_sync_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_meta_q <= bus.scl_i;
      scl_sync_q <= scl_meta_q;
      scl_prev_q <= scl_sync_q;
      sda_meta_q <= bus.sda_i;
      sda_sync_q <= sda_meta_q;
      sda_prev_q <= sda_sync_q;
    end
  end

  assign scl_rise_s  = scl_sync_q & ~scl_prev_q;
  assign scl_fall_s  = ~scl_sync_q & scl_prev_q;
  assign start_det_s = scl_sync_q & sda_prev_q & ~sda_sync_q;
  assign stop_det_s  = scl_sync_q & ~sda_prev_q & sda_sync_q;

  // Next-state logic: bus conditions first, then per-state bit handling
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    phase_d     = phase_q;
    ack_d       = ack_q;
    addressed_d = addressed_q;
    oen_d       = oen_q;
    rx_data_d   = rx_data_q;
    rw_d        = rw_q;
    busy_d      = busy_q;
    rx_valid_d  = 1'b0;
    tx_req_d    = 1'b0;
    start_d     = 1'b0;
    stop_d      = 1'b0;

    if (start_det_s) begin
      state_d     = ST_ADDR;
      cnt_d       = 3'd0;
      phase_d     = 1'b0;
      oen_d       = 1'b0;
      busy_d      = 1'b1;
      addressed_d = 1'b0;
    end else if (stop_det_s) begin
      state_d     = ST_IDLE;
      cnt_d       = 3'd0;
      phase_d     = 1'b0;
      oen_d       = 1'b0;
      busy_d      = 1'b0;
      stop_d      = addressed_q;
      addressed_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          oen_d = 1'b0;
        end
        ST_ADDR: begin
          if (scl_rise_s) begin
            shift_d = {shift_q[6:0], sda_sync_q};
            cnt_d   = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              if (shift_q[6:0] == ADDR) begin
                start_d     = 1'b1;
                rw_d        = sda_sync_q;
                addressed_d = 1'b1;
                phase_d     = 1'b0;
                state_d     = ST_ADDR_ACK;
              end else begin
                state_d = ST_IDLE;
              end
            end else begin
              state_d = ST_ADDR;
            end
          end else begin
            state_d = ST_ADDR;
          end
        end
        ST_ADDR_ACK: begin
          if (scl_fall_s) begin
            if (!phase_q) begin
              phase_d = 1'b1;
              oen_d   = 1'b1;
            end else begin
              phase_d = 1'b0;
              if (rw_q) begin
                shift_d  = bus.tx_data_i;
                tx_req_d = 1'b1;
                oen_d    = ~bus.tx_data_i[7];
                state_d  = ST_TX_DATA;
              end else begin
                oen_d   = 1'b0;
                state_d = ST_RX_DATA;
              end
            end
          end else begin
            state_d = ST_ADDR_ACK;
          end
        end
        ST_RX_DATA: begin
          if (scl_rise_s) begin
            shift_d = {shift_q[6:0], sda_sync_q};
            cnt_d   = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              if (bus.rx_ready_i) begin
                rx_data_d  = {shift_q[6:0], sda_sync_q};
                rx_valid_d = 1'b1;
                ack_d      = 1'b1;
              end else begin
                ack_d = 1'b0;
              end
              phase_d = 1'b0;
              state_d = ST_RX_ACK;
            end else begin
              state_d = ST_RX_DATA;
            end
          end else begin
            state_d = ST_RX_DATA;
          end
        end
        ST_RX_ACK: begin
          if (scl_fall_s) begin
            if (!phase_q) begin
              phase_d = 1'b1;
              oen_d   = ack_q;
            end else begin
              phase_d = 1'b0;
              oen_d   = 1'b0;
              state_d = ST_RX_DATA;
            end
          end else begin
            state_d = ST_RX_ACK;
          end
        end
        ST_TX_DATA: begin
          if (scl_rise_s) begin
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              phase_d = 1'b0;
              state_d = ST_TX_ACK;
            end else begin
              state_d = ST_TX_DATA;
            end
          end else if (scl_fall_s) begin
            shift_d = {shift_q[6:0], 1'b0};
            oen_d   = ~shift_q[6];
          end else begin
            state_d = ST_TX_DATA;
          end
        end
        ST_TX_ACK: begin
          if (scl_fall_s) begin
            if (!phase_q) begin
              phase_d = 1'b1;
              oen_d   = 1'b0;
            end else begin
              // Controller ACKed: present the next byte
              phase_d  = 1'b0;
              shift_d  = bus.tx_data_i;
              tx_req_d = 1'b1;
              oen_d    = ~bus.tx_data_i[7];
              state_d  = ST_TX_DATA;
            end
          end else if (scl_rise_s && phase_q) begin
            if (sda_sync_q) begin
              // Controller NACK ends the read; stay off the bus until STOP/START
              phase_d = 1'b0;
              oen_d   = 1'b0;
              state_d = ST_IDLE;
            end else begin
              state_d = ST_TX_ACK;
            end
          end else begin
            state_d = ST_TX_ACK;
          end
        end
        default: begin
          state_d = ST_IDLE;
          oen_d   = 1'b0;
        end
      endcase
    end
  end

  // State and registered outputs; reset releases SDA asynchronously
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 3'd0;
      shift_q     <= 8'd0;
      phase_q     <= 1'b0;
      ack_q       <= 1'b0;
      addressed_q <= 1'b0;
      oen_q       <= 1'b0;
      rx_data_q   <= 8'd0;
      rx_valid_q  <= 1'b0;
      tx_req_q    <= 1'b0;
      start_q     <= 1'b0;
      rw_q        <= 1'b0;
      stop_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      phase_q     <= phase_d;
      ack_q       <= ack_d;
      addressed_q <= addressed_d;
      oen_q       <= oen_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      tx_req_q    <= tx_req_d;
      start_q     <= start_d;
      rw_q        <= rw_d;
      stop_q      <= stop_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.sda_o      = 1'b0;
  assign bus.sda_oen_o  = oen_q;
  assign bus.rx_data_o  = rx_data_q;
  assign bus.rx_valid_o = rx_valid_q;
  assign bus.tx_req_o   = tx_req_q;
  assign bus.start_o    = start_q;
  assign bus.rw_o       = rw_q;
  assign bus.stop_o     = stop_q;
  assign bus.busy_o     = busy_q;

endmodule

// File: tb/tb_i2c_target.sv
// Directed + randomized bench for i2c_target: a bit-level I2C controller model
// drives the open-drain bus, and transaction-level expectations are computed
// from the address / ready / ACK rules.
`timescale 1ns/1ps
module tb_i2c_target;

  localparam logic [6:0] TGT = 7'h50;
  localparam int Q = 8;  // clk cycles per quarter SCL period

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic m_scl = 1'b1;
  logic m_sda = 1'b1;
  logic rx_ready = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic sda_line;

  int checks = 0;
  int errors = 0;

  // Monitor counters (written only by the monitor)
  int n_start = 0, n_stop = 0, n_rxv = 0, n_txr = 0, n_oen = 0, n_dbl = 0;
  logic p_start = 1'b0, p_stop = 1'b0, p_rxv = 1'b0, p_txr = 1'b0;
  logic [7:0] rxq [$];

  // Model state
  logic [7:0] exp_rx_data = 8'h00;
  logic       exp_rw = 1'b0;

  i2c_target_if bus ();

  assign sda_line       = m_sda & ~bus.sda_oen_o;
  assign bus.scl_i      = m_scl;
  assign bus.sda_i      = sda_line;
  assign bus.rx_ready_i = rx_ready;
  assign bus.tx_data_i  = tx_data;

  i2c_target #(.ADDR(TGT)) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Pulse / drive monitor sampled on the inactive edge
  always @(negedge clk) begin
    if (bus.start_o)    n_start <= n_start + 1;
    if (bus.stop_o)     n_stop  <= n_stop + 1;
    if (bus.rx_valid_o) n_rxv   <= n_rxv + 1;
    if (bus.tx_req_o)   n_txr   <= n_txr + 1;
    if (bus.sda_oen_o)  n_oen   <= n_oen + 1;
    if (bus.rx_valid_o) rxq.push_back(bus.rx_data_o);
    if ((bus.start_o & p_start) | (bus.stop_o & p_stop) |
        (bus.rx_valid_o & p_rxv) | (bus.tx_req_o & p_txr))
      n_dbl <= n_dbl + 1;
    p_start <= bus.start_o;
    p_stop  <= bus.stop_o;
    p_rxv   <= bus.rx_valid_o;
    p_txr   <= bus.tx_req_o;
  end

  // Global time limit
  initial begin
    #5_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_start();
    m_sda = 1'b1;
    tick(Q);
    if (m_scl == 1'b0) begin
      m_scl = 1'b1;
      tick(Q);
    end
    m_sda = 1'b0;
    tick(Q);
    m_scl = 1'b0;
    tick(Q);
  endtask

  task automatic bus_stop();
    m_sda = 1'b0;
    tick(Q);
    m_scl = 1'b1;
    tick(Q);
    m_sda = 1'b1;
    tick(Q);
  endtask

  task automatic send_bits(input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      tick(Q);
      m_sda = b[7-i];
      tick(Q);
      m_scl = 1'b1;
      tick(2*Q);
      m_scl = 1'b0;
    end
  endtask

  task automatic get_ack(output logic ack);
    tick(Q);
    m_sda = 1'b1;
    tick(Q);
    m_scl = 1'b1;
    tick(Q);
    ack = ~sda_line;
    tick(Q);
    m_scl = 1'b0;
  endtask

  task automatic recv_bits(output logic [7:0] b);
    b = 8'h00;
    for (int i = 0; i < 8; i++) begin
      tick(Q);
      m_sda = 1'b1;
      tick(Q);
      m_scl = 1'b1;
      tick(Q);
      b = {b[6:0], sda_line};
      tick(Q);
      m_scl = 1'b0;
    end
  endtask

  task automatic send_ack(input logic nack);
    tick(Q);
    m_sda = nack;
    tick(Q);
    m_scl = 1'b1;
    tick(2*Q);
    m_scl = 1'b0;
  endtask

  // Full write transaction: START, address byte, n data bytes, STOP
  task automatic do_write(input string tag, input logic [7:0] ab, input int n,
                          input logic [7:0] d [4], input logic rdy [4]);
    int s_start, s_stop, s_rxv, s_oen, s_q, n_acc;
    logic a, match;
    logic [7:0] accq [$];
    s_start = n_start; s_stop = n_stop; s_rxv = n_rxv; s_oen = n_oen; s_q = rxq.size();
    match = (ab[7:1] == TGT) && (ab[0] == 1'b0);
    n_acc = 0;
    bus_start();
    check({tag, " busy"}, 32'(bus.busy_o), 32'd1);
    send_bits(ab, 8);
    get_ack(a);
    check({tag, " addr_ack"}, 32'(a), 32'(match));
    if (match) exp_rw = 1'b0;
    for (int i = 0; i < n; i++) begin
      rx_ready = rdy[i];
      send_bits(d[i], 8);
      get_ack(a);
      check($sformatf("%s data_ack%0d", tag, i), 32'(a), 32'(match & rdy[i]));
      if (match && rdy[i]) begin
        accq.push_back(d[i]);
        exp_rx_data = d[i];
        n_acc++;
      end
      check($sformatf("%s rx_data%0d", tag, i), 32'(bus.rx_data_o), 32'(exp_rx_data));
    end
    rx_ready = 1'b1;
    bus_stop();
    tick(4);
    check({tag, " start_cnt"}, 32'(n_start - s_start), 32'(match));
    check({tag, " stop_cnt"}, 32'(n_stop - s_stop), 32'(match));
    check({tag, " rxv_cnt"}, 32'(n_rxv - s_rxv), 32'(n_acc));
    check({tag, " busy_end"}, 32'(bus.busy_o), 32'd0);
    check({tag, " rw"}, 32'(bus.rw_o), 32'(exp_rw));
    if (!match) check({tag, " never_driven"}, 32'(n_oen - s_oen), 32'd0);
    for (int i = 0; i < n_acc; i++) begin
      if (s_q + i < rxq.size())
        check($sformatf("%s rxq%0d", tag, i), 32'(rxq[s_q + i]), 32'(accq[i]));
      else
        check($sformatf("%s rxq%0d_missing", tag, i), 32'd0, 32'd1);
    end
  endtask

  // Read transaction: controller ACKs every byte but the last
  task automatic do_read(input string tag, input int n, input logic [7:0] tx [4]);
    int s_start, s_stop, s_txr, s_rxv;
    logic a;
    logic [7:0] b;
    s_start = n_start; s_stop = n_stop; s_txr = n_txr; s_rxv = n_rxv;
    tx_data = tx[0];
    bus_start();
    send_bits({TGT, 1'b1}, 8);
    get_ack(a);
    check({tag, " addr_ack"}, 32'(a), 32'd1);
    exp_rw = 1'b1;
    for (int i = 0; i < n; i++) begin
      recv_bits(b);
      if (i < n - 1) tx_data = tx[i+1];
      send_ack(i == n - 1);
      check($sformatf("%s byte%0d", tag, i), 32'(b), 32'(tx[i]));
    end
    tick(Q);
    check({tag, " released"}, 32'(bus.sda_oen_o), 32'd0);
    bus_stop();
    tick(4);
    check({tag, " txreq_cnt"}, 32'(n_txr - s_txr), 32'(n));
    check({tag, " start_cnt"}, 32'(n_start - s_start), 32'd1);
    check({tag, " stop_cnt"}, 32'(n_stop - s_stop), 32'd1);
    check({tag, " rxv_cnt"}, 32'(n_rxv - s_rxv), 32'd0);
    check({tag, " rw"}, 32'(bus.rw_o), 32'd1);
  endtask

  initial begin
    logic [7:0] dd [4];
    logic rr [4];
    logic a;
    logic [7:0] b;
    int s_rxv, s_start, s_stop;

    // Reset state
    tick(3);
    check("rst sda_o", 32'(bus.sda_o), 32'd0);
    check("rst oen", 32'(bus.sda_oen_o), 32'd0);
    check("rst rx_data", 32'(bus.rx_data_o), 32'd0);
    check("rst pulses", 32'({bus.rx_valid_o, bus.tx_req_o, bus.start_o, bus.stop_o}), 32'd0);
    check("rst rw_busy", 32'({bus.rw_o, bus.busy_o}), 32'd0);
    rst_n = 1'b1;
    tick(Q);

    // Basic write 0xA0, 0x3C
    dd = '{8'h3C, 8'h00, 8'h00, 8'h00};
    rr = '{1'b1, 1'b1, 1'b1, 1'b1};
    do_write("wr_basic", 8'hA0, 1, dd, rr);

    // Wrong address 0xA2: ignored entirely
    do_write("wr_noaddr", 8'hA2, 1, dd, rr);

    // Read 0x96 then 0x5A, ACK then NACK
    dd = '{8'h96, 8'h5A, 8'h00, 8'h00};
    do_read("rd_basic", 2, dd);

    // Write with user not ready on byte 2
    dd = '{8'(($urandom)), 8'(($urandom)), 8'(($urandom)), 8'h00};
    rr = '{1'b1, 1'b0, 1'b1, 1'b1};
    do_write("wr_notready", 8'hA0, 3, dd, rr);

    // Repeated START mid-write, then read
    s_rxv = n_rxv; s_start = n_start; s_stop = n_stop;
    bus_start();
    send_bits(8'hA0, 8);
    get_ack(a);
    check("rs addr_ack", 32'(a), 32'd1);
    send_bits(8'(($urandom)), 4);
    tx_data = 8'(($urandom));
    dd[0] = tx_data;
    bus_start();
    send_bits({TGT, 1'b1}, 8);
    get_ack(a);
    check("rs rd_ack", 32'(a), 32'd1);
    recv_bits(b);
    send_ack(1'b1);
    check("rs byte", 32'(b), 32'(dd[0]));
    bus_stop();
    tick(4);
    exp_rw = 1'b1;
    check("rs rxv_cnt", 32'(n_rxv - s_rxv), 32'd0);
    check("rs start_cnt", 32'(n_start - s_start), 32'd2);
    check("rs stop_cnt", 32'(n_stop - s_stop), 32'd1);
    check("rs rw", 32'(bus.rw_o), 32'd1);

    // Reset while the target is driving ACK
    bus_start();
    send_bits(8'hA0, 8);
    tick(Q);
    m_sda = 1'b1;
    tick(Q);
    m_scl = 1'b1;
    tick(Q);
    check("rst_mid ack_driven", 32'(bus.sda_oen_o), 32'd1);
    #3 rst_n = 1'b0;
    #1;
    check("rst_mid async_release", 32'(bus.sda_oen_o), 32'd0);
    check("rst_mid busy", 32'(bus.busy_o), 32'd0);
    exp_rx_data = 8'h00;
    exp_rw = 1'b0;
    tick(2);
    rst_n = 1'b1;
    s_stop = n_stop; s_start = n_start;
    tick(Q);
    m_scl = 1'b0;
    send_bits(8'h3C, 8);   // ignored bus traffic
    tick(Q);
    bus_stop();
    tick(4);
    check("rst_mid no_stop", 32'(n_stop - s_stop), 32'd0);
    check("rst_mid no_start", 32'(n_start - s_start), 32'd0);
    dd = '{8'(($urandom)), 8'h00, 8'h00, 8'h00};
    rr = '{1'b1, 1'b1, 1'b1, 1'b1};
    do_write("wr_after_rst", 8'hA0, 1, dd, rr);

    // Randomized writes and reads against the transaction model
    for (int k = 0; k < 4; k++) begin
      logic [7:0] ab;
      ab = ($urandom_range(0, 1) == 0) ? {TGT, 1'b0} : {7'(($urandom)), 1'b0};
      for (int i = 0; i < 4; i++) begin
        dd[i] = 8'(($urandom));
        rr[i] = 1'($urandom_range(0, 1));
      end
      do_write($sformatf("wr_rand%0d", k), ab, int'($urandom_range(1, 4)), dd, rr);
      for (int i = 0; i < 4; i++) dd[i] = 8'(($urandom));
      do_read($sformatf("rd_rand%0d", k), int'($urandom_range(1, 4)), dd);
    end

    check("pulse_width", 32'(n_dbl), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
